// File: rtl/dcache_pkg.sv
// Shared types and sizing constants for the 4-way write-back data cache controller.
package dcache_pkg;

    localparam int S_OFFSET  = 5;
    localparam int S_INDEX   = 5;
    localparam int NUM_WAYS  = 4;
    localparam int NUM_SETS  = 2 ** S_INDEX;
    localparam int LINE_BITS = 8 * (2 ** S_OFFSET);
    localparam int MASK_BITS = 2 ** S_OFFSET;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    typedef logic [1:0] way_t;
    typedef logic [2:0] plru_t;

endpackage

// File: rtl/dcache_if.sv
// CPU request/response and physical-memory handshake bundle seen by the cache controller.
interface dcache_if;
    import dcache_pkg::*;

    logic                 mem_read;
    logic                 mem_write;
    logic [MASK_BITS-1:0] mem_byte_enable256;
    logic                 mem_resp;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_resp;

    // The controller is the slave of the CPU request and the initiator of pmem traffic.
    modport master (
        output mem_read, mem_write, mem_byte_enable256, pmem_resp,
        input  mem_resp, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable256, pmem_resp,
        output mem_resp, pmem_read, pmem_write
    );

endinterface

// File: rtl/dcache_plru.sv
// Combinational tree-PLRU: victim choice from the current bits and the update for a touched way.
module dcache_plru
    import dcache_pkg::*;
(
    input  plru_t lru,
    input  way_t  way,
    output way_t  victim,
    output plru_t set_lru
);

    // lru[0] picks the half, lru[1]/lru[2] pick the way inside the left/right half.
    always_comb begin
        victim = lru[0] ? (lru[2] ? 2'd3 : 2'd2) : (lru[1] ? 2'd1 : 2'd0);
        case (way)
            2'd0:    set_lru = {lru[2], 1'b1, 1'b1};
            2'd1:    set_lru = {lru[2], 1'b0, 1'b1};
            2'd2:    set_lru = {1'b1, lru[1], 1'b0};
            default: set_lru = {1'b0, lru[1], 1'b0};
        endcase
    end

endmodule

// File: rtl/dcache_control.sv
// Sequencing FSM for the 4-way, 32-set, 256-bit-line write-back data cache.
// Define DCACHE_PERF_CNT_EN to add hit/miss/writeback counters.
module dcache_control
    import dcache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dcache_if.slave              bus,
    input  logic [NUM_WAYS-1:0]  hit_datapath,
    input  plru_t                lru_output,
    input  logic [NUM_WAYS-1:0]  valid_out,
    input  logic [NUM_WAYS-1:0]  dirty_out,
    output logic                 mem_read_delayed,
    output logic                 mem_write_delayed,
    output logic                 load_lru,
    output plru_t                set_lru,
    output logic [NUM_WAYS-1:0]  load_dirty,
    output logic                 set_dirty,
    output logic [NUM_WAYS-1:0]  load_valid,
    output logic [NUM_WAYS-1:0]  load_tag,
    output logic [NUM_WAYS-1:0]  wren,
    output logic [MASK_BITS-1:0] write_enable_0,
    output logic [MASK_BITS-1:0] write_enable_1,
    output logic [MASK_BITS-1:0] write_enable_2,
    output logic [MASK_BITS-1:0] write_enable_3,
    output logic                 mem_enable_sel
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
    output logic [31:0]          wb_count
`endif
);

    state_t               state, state_next;
    way_t                 victim_q, victim_sel, hit_way;
    plru_t                plru_set;
    logic                 hit_any;
    logic                 req_read_q, req_write_q;
    logic [MASK_BITS-1:0] write_mask;

    assign hit_any = |hit_datapath;

    // Lowest-numbered way wins if the datapath ever reports more than one hit.
    always_comb begin
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_datapath[w]) hit_way = way_t'(w);
        end
    end

    dcache_plru u_plru (
        .lru     (lru_output),
        .way     (hit_way),
        .victim  (victim_sel),
        .set_lru (plru_set)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            victim_q    <= '0;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && (bus.mem_read || bus.mem_write)) begin
                req_write_q <= bus.mem_write;
                req_read_q  <= bus.mem_read & ~bus.mem_write;
            end
            if (state == LOOKUP && !hit_any) victim_q <= victim_sel;
        end
    end

    always_comb begin
        state_next        = state;
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        mem_read_delayed  = 1'b0;
        mem_write_delayed = 1'b0;
        load_lru          = 1'b0;
        set_lru           = '0;
        load_dirty        = '0;
        set_dirty         = 1'b0;
        load_valid        = '0;
        load_tag          = '0;
        wren              = '0;
        write_mask        = '0;
        mem_enable_sel    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read || bus.mem_write) state_next = LOOKUP;
            end
            LOOKUP: begin
                mem_read_delayed  = req_read_q;
                mem_write_delayed = req_write_q;
                if (hit_any) begin
                    bus.mem_resp = 1'b1;
                    load_lru     = 1'b1;
                    set_lru      = plru_set;
                    if (req_write_q) begin
                        wren[hit_way]       = 1'b1;
                        write_mask          = bus.mem_byte_enable256;
                        load_dirty[hit_way] = 1'b1;
                        set_dirty           = 1'b1;
                    end
                    state_next = IDLE;
                end else if (valid_out[victim_sel] && dirty_out[victim_sel]) begin
                    state_next = WRITEBACK;
                end else begin
                    state_next = ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.pmem_write = 1'b1;
                if (bus.pmem_resp) state_next = ALLOCATE;
            end
            ALLOCATE: begin
                bus.pmem_read  = 1'b1;
                mem_enable_sel = 1'b1;
                // The fill lands the whole line clean; a pending write merges on the re-lookup.
                if (bus.pmem_resp) begin
                    wren[victim_q]       = 1'b1;
                    write_mask           = '1;
                    load_tag[victim_q]   = 1'b1;
                    load_valid[victim_q] = 1'b1;
                    load_dirty[victim_q] = 1'b1;
                    state_next           = REFILL;
                end
            end
            REFILL: begin
                state_next = LOOKUP;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign write_enable_0 = wren[0] ? write_mask : '0;
    assign write_enable_1 = wren[1] ? write_mask : '0;
    assign write_enable_2 = wren[2] ? write_mask : '0;
    assign write_enable_3 = wren[3] ? write_mask : '0;

`ifdef DCACHE_PERF_CNT_EN
    logic after_refill_q;

    // The guaranteed hit that follows a refill belongs to the miss, not to the hit count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count      <= '0;
            miss_count     <= '0;
            wb_count       <= '0;
            after_refill_q <= 1'b0;
        end else begin
            after_refill_q <= (state == REFILL);
            if (state == LOOKUP && hit_any && !after_refill_q) hit_count <= hit_count + 32'd1;
            if (state == LOOKUP && !hit_any) miss_count <= miss_count + 32'd1;
            if (state == WRITEBACK && bus.pmem_resp) wb_count <= wb_count + 32'd1;
        end
    end
`endif

    a_onehot_hit: assert property (@(posedge clk) disable iff (!rst)
        (state == LOOKUP) |-> $onehot0(hit_datapath));

    a_pmem_excl: assert property (@(posedge clk) disable iff (!rst)
        !(bus.pmem_read && bus.pmem_write));

endmodule

// File: tb/tb_dcache_control.sv
// Directed, table-driven bench for dcache_control; define DCACHE_PERF_CNT_EN to also check the counters.
module tb_dcache_control;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  hit_datapath, valid_out, dirty_out;
    logic [2:0]  lru_output;
    logic        mem_read_delayed, mem_write_delayed, load_lru, set_dirty, mem_enable_sel;
    logic [2:0]  set_lru;
    logic [3:0]  load_dirty, load_valid, load_tag, wren;
    logic [31:0] write_enable_0, write_enable_1, write_enable_2, write_enable_3;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count, wb_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache_if bus();

    always #5 clk = ~clk;

    dcache_control dut (
        .clk               (clk),
        .rst               (rst),
        .bus               (bus),
        .hit_datapath      (hit_datapath),
        .lru_output        (lru_output),
        .valid_out         (valid_out),
        .dirty_out         (dirty_out),
        .mem_read_delayed  (mem_read_delayed),
        .mem_write_delayed (mem_write_delayed),
        .load_lru          (load_lru),
        .set_lru           (set_lru),
        .load_dirty        (load_dirty),
        .set_dirty         (set_dirty),
        .load_valid        (load_valid),
        .load_tag          (load_tag),
        .wren              (wren),
        .write_enable_0    (write_enable_0),
        .write_enable_1    (write_enable_1),
        .write_enable_2    (write_enable_2),
        .write_enable_3    (write_enable_3),
        .mem_enable_sel    (mem_enable_sel)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count),
        .wb_count          (wb_count)
`endif
    );

    typedef struct {
        logic        rd, wr;
        logic [31:0] be;
        logic [3:0]  hit;
        logic [2:0]  lru;
        logic [3:0]  valid, dirty;
        logic        e_resp, e_load_lru;
        logic [2:0]  e_set_lru;
        logic [3:0]  e_wren, e_load_dirty;
        logic        e_set_dirty;
        logic [127:0] e_we;
        logic        e_rd_d, e_wr_d, e_pmem_rd, e_pmem_wr;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [127:0] we_all();
        return {write_enable_3, write_enable_2, write_enable_1, write_enable_0};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    task automatic clearInputs();
        bus.mem_read           = 1'b0;
        bus.mem_write          = 1'b0;
        bus.mem_byte_enable256 = '0;
        bus.pmem_resp          = 1'b0;
        hit_datapath           = '0;
        lru_output             = '0;
        valid_out              = '0;
        dirty_out              = '0;
    endtask

    // One request: IDLE cycle, LOOKUP cycle checked against the record, then the following state.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        bus.mem_read           = v.rd;
        bus.mem_write          = v.wr;
        bus.mem_byte_enable256 = v.be;
        hit_datapath           = v.hit;
        lru_output             = v.lru;
        valid_out              = v.valid;
        dirty_out              = v.dirty;
        #1;
        checkOutput($sformatf("v%0d.idle_resp", idx), 128'(bus.mem_resp), 128'(0));
        @(negedge clk);
        #1;
        checkOutput($sformatf("v%0d.mem_resp", idx), 128'(bus.mem_resp), 128'(v.e_resp));
        checkOutput($sformatf("v%0d.load_lru", idx), 128'(load_lru), 128'(v.e_load_lru));
        checkOutput($sformatf("v%0d.set_lru", idx), 128'(set_lru), 128'(v.e_set_lru));
        checkOutput($sformatf("v%0d.wren", idx), 128'(wren), 128'(v.e_wren));
        checkOutput($sformatf("v%0d.load_dirty", idx), 128'(load_dirty), 128'(v.e_load_dirty));
        checkOutput($sformatf("v%0d.set_dirty", idx), 128'(set_dirty), 128'(v.e_set_dirty));
        checkOutput($sformatf("v%0d.write_enable", idx), we_all(), v.e_we);
        checkOutput($sformatf("v%0d.read_delayed", idx), 128'(mem_read_delayed), 128'(v.e_rd_d));
        checkOutput($sformatf("v%0d.write_delayed", idx), 128'(mem_write_delayed), 128'(v.e_wr_d));
        @(negedge clk);
        #1;
        checkOutput($sformatf("v%0d.next_pmem_read", idx), 128'(bus.pmem_read), 128'(v.e_pmem_rd));
        checkOutput($sformatf("v%0d.next_pmem_write", idx), 128'(bus.pmem_write), 128'(v.e_pmem_wr));
        checkOutput($sformatf("v%0d.next_mem_resp", idx), 128'(bus.mem_resp), 128'(0));
        clearInputs();
        if (v.hit == 4'b0000) doReset();
    endtask

    // Cold read miss into way0, then pmem_resp ignored while idle.
    task automatic seqColdRead();
        @(negedge clk);
        bus.mem_read = 1'b1; lru_output = 3'b000; valid_out = '0; dirty_out = '0; hit_datapath = '0;
        @(negedge clk); #1;
        checkOutput("cold.lookup_resp", 128'(bus.mem_resp), 128'(0));
        checkOutput("cold.read_delayed", 128'(mem_read_delayed), 128'(1));
        @(negedge clk); #1;
        checkOutput("cold.pmem_read", 128'(bus.pmem_read), 128'(1));
        checkOutput("cold.mem_enable_sel", 128'(mem_enable_sel), 128'(1));
        checkOutput("cold.pmem_write", 128'(bus.pmem_write), 128'(0));
        checkOutput("cold.wren_wait", 128'(wren), 128'(0));
        @(negedge clk); #1;
        checkOutput("cold.pmem_read_held", 128'(bus.pmem_read), 128'(1));
        bus.pmem_resp = 1'b1;
        #1;
        checkOutput("cold.fill_wren", 128'(wren), 128'(4'b0001));
        checkOutput("cold.fill_we", we_all(), {96'h0, 32'hFFFF_FFFF});
        checkOutput("cold.fill_load_tag", 128'(load_tag), 128'(4'b0001));
        checkOutput("cold.fill_load_valid", 128'(load_valid), 128'(4'b0001));
        checkOutput("cold.fill_load_dirty", 128'(load_dirty), 128'(4'b0001));
        checkOutput("cold.fill_set_dirty", 128'(set_dirty), 128'(0));
        @(negedge clk);
        bus.pmem_resp = 1'b0; hit_datapath = 4'b0001;
        #1;
        checkOutput("cold.refill_pmem_read", 128'(bus.pmem_read), 128'(0));
        checkOutput("cold.refill_resp", 128'(bus.mem_resp), 128'(0));
        checkOutput("cold.refill_wren", 128'(wren), 128'(0));
        @(negedge clk); #1;
        checkOutput("cold.hit_resp", 128'(bus.mem_resp), 128'(1));
        checkOutput("cold.hit_load_lru", 128'(load_lru), 128'(1));
        checkOutput("cold.hit_set_lru", 128'(set_lru), 128'(3'b011));
        checkOutput("cold.hit_wren", 128'(wren), 128'(0));
        @(negedge clk);
        clearInputs();
        bus.pmem_resp = 1'b1;
        #1;
        checkOutput("cold.idle_resp", 128'(bus.mem_resp), 128'(0));
        @(negedge clk); #1;
        checkOutput("idle_ignore.pmem_read", 128'(bus.pmem_read), 128'(0));
        checkOutput("idle_ignore.pmem_write", 128'(bus.pmem_write), 128'(0));
        checkOutput("idle_ignore.mem_resp", 128'(bus.mem_resp), 128'(0));
        bus.pmem_resp = 1'b0;
    endtask

    // Dirty write miss on way3: writeback, fill, then merged write hit.
    task automatic seqDirtyMiss();
        @(negedge clk);
        bus.mem_write = 1'b1; bus.mem_byte_enable256 = 32'h0000_00FF;
        lru_output = 3'b101; valid_out = 4'b1000; dirty_out = 4'b1000; hit_datapath = '0;
        @(negedge clk); #1;
        checkOutput("dirty.lookup_resp", 128'(bus.mem_resp), 128'(0));
        checkOutput("dirty.write_delayed", 128'(mem_write_delayed), 128'(1));
        @(negedge clk);
        lru_output = 3'b000;
        #1;
        checkOutput("dirty.wb_pmem_write", 128'(bus.pmem_write), 128'(1));
        checkOutput("dirty.wb_pmem_read", 128'(bus.pmem_read), 128'(0));
        @(negedge clk); #1;
        checkOutput("dirty.wb_excl", 128'(bus.pmem_read & bus.pmem_write), 128'(0));
        bus.pmem_resp = 1'b1;
        #1;
        checkOutput("dirty.wb_resp_pmem_write", 128'(bus.pmem_write), 128'(1));
        checkOutput("dirty.wb_resp_wren", 128'(wren), 128'(0));
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        checkOutput("dirty.alloc_pmem_read", 128'(bus.pmem_read), 128'(1));
        checkOutput("dirty.alloc_pmem_write", 128'(bus.pmem_write), 128'(0));
        @(negedge clk);
        bus.pmem_resp = 1'b1;
        #1;
        checkOutput("dirty.fill_wren", 128'(wren), 128'(4'b1000));
        checkOutput("dirty.fill_load_tag", 128'(load_tag), 128'(4'b1000));
        checkOutput("dirty.fill_we", we_all(), {32'hFFFF_FFFF, 96'h0});
        checkOutput("dirty.fill_set_dirty", 128'(set_dirty), 128'(0));
        @(negedge clk);
        bus.pmem_resp = 1'b0; hit_datapath = 4'b1000; lru_output = 3'b101;
        #1;
        checkOutput("dirty.refill_resp", 128'(bus.mem_resp), 128'(0));
        @(negedge clk); #1;
        checkOutput("dirty.hit_resp", 128'(bus.mem_resp), 128'(1));
        checkOutput("dirty.hit_wren", 128'(wren), 128'(4'b1000));
        checkOutput("dirty.hit_we", we_all(), {32'h0000_00FF, 96'h0});
        checkOutput("dirty.hit_load_dirty", 128'(load_dirty), 128'(4'b1000));
        checkOutput("dirty.hit_set_dirty", 128'(set_dirty), 128'(1));
        checkOutput("dirty.hit_set_lru", 128'(set_lru), 128'(3'b000));
        @(negedge clk);
        clearInputs();
    endtask

    // Async reset while ALLOCATE holds pmem_read.
    task automatic seqResetAlloc();
        @(negedge clk);
        bus.mem_read = 1'b1; lru_output = 3'b000; valid_out = '0; dirty_out = '0; hit_datapath = '0;
        @(negedge clk);
        @(negedge clk); #1;
        checkOutput("rstalloc.pmem_read", 128'(bus.pmem_read), 128'(1));
        rst = 1'b0;
        #1;
        checkOutput("rstalloc.pmem_read_drop", 128'(bus.pmem_read), 128'(0));
        checkOutput("rstalloc.mem_enable_sel", 128'(mem_enable_sel), 128'(0));
        checkOutput("rstalloc.mem_resp", 128'(bus.mem_resp), 128'(0));
        clearInputs();
        @(negedge clk); #1;
        checkOutput("rstalloc.held_pmem_read", 128'(bus.pmem_read), 128'(0));
        rst = 1'b1;
        applyStimulus(vecs[0], 100);
    endtask

    initial begin
        //          rd   wr   be            hit      lru     valid    dirty    resp llru set    wren     ldirty   sd   we                                             rdd  wrd  prd  pwr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,        4'b0001, 3'b000, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'b011, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,        4'b0010, 3'b110, 4'b0010, 4'b0000, 1'b1, 1'b1, 3'b101, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        4'b1000, 3'b011, 4'b1000, 4'b0000, 1'b1, 1'b1, 3'b010, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000000F, 4'b0100, 3'b010, 4'b0100, 4'b0000, 1'b1, 1'b1, 3'b110, 4'b0100, 4'b0100, 1'b1, {32'h0, 32'h0000000F, 64'h0},           1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'hFFFF0000, 4'b0010, 3'b111, 4'b0010, 4'b0000, 1'b1, 1'b1, 3'b101, 4'b0010, 4'b0010, 1'b1, {64'h0, 32'hFFFF0000, 32'h0},           1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 32'h12345678, 4'b0001, 3'b100, 4'b0001, 4'b0000, 1'b1, 1'b1, 3'b111, 4'b0001, 4'b0001, 1'b1, {96'h0, 32'h12345678},                   1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,        4'b0000, 3'b000, 4'b0000, 4'b0000, 1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,        4'b0000, 3'b101, 4'b1111, 4'b1000, 1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,        4'b0000, 3'b001, 4'b1111, 4'b1011, 1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,        4'b0000, 3'b010, 4'b0010, 4'b0010, 1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h000000AA, 4'b0000, 3'b110, 4'b0000, 4'b0010, 1'b0, 1'b0, 3'b000, 4'b0000, 4'b0000, 1'b0, 128'h0,                                    1'b0, 1'b1, 1'b1, 1'b0};

        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("reset.mem_resp", 128'(bus.mem_resp), 128'(0));
        checkOutput("reset.pmem_read", 128'(bus.pmem_read), 128'(0));
        checkOutput("reset.pmem_write", 128'(bus.pmem_write), 128'(0));
        checkOutput("reset.wren", 128'(wren), 128'(0));
        checkOutput("reset.we", we_all(), 128'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        $display("[TB] cold read miss");
        seqColdRead();
        applyStimulus(vecs[1], 101);

        $display("[TB] reset during allocate");
        seqResetAlloc();

        $display("[TB] hits then dirty miss");
        @(negedge clk);
        doReset();
`ifdef DCACHE_PERF_CNT_EN
        checkOutput("perf.reset_hits", 128'(hit_count), 128'(0));
`endif
        for (int i = 0; i < 3; i++) applyStimulus(vecs[i], 200 + i);
        seqDirtyMiss();
`ifdef DCACHE_PERF_CNT_EN
        #1;
        checkOutput("perf.hit_count", 128'(hit_count), 128'(3));
        checkOutput("perf.miss_count", 128'(miss_count), 128'(1));
        checkOutput("perf.wb_count", 128'(wb_count), 128'(1));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_control.md
Name: dcache_control

Overview:
Sequencing FSM for the 4-way set-associative, 32-set, 256-bit-line write-back data cache datapath. It accepts CPU read/write requests and issues all array load/write strobes, tree-PLRU updates, dirty/valid/tag updates and physical-memory read/write handshakes. It sits between the CPU bus adapter and the cache datapath, with the cacheline arbiter/pmem port below.

Parameters:
- s_offset, 5, byte-offset bits; line = 2**s_offset bytes.
- s_index, 5, index bits; 2**s_index sets.
- num_ways, 4, associativity; fixed at 4 for the 3-bit tree-PLRU.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable256  in  32  byte enables for the 256-bit line write.
- mem_resp  out  1  one-cycle completion pulse to the CPU.
- pmem_resp  in  1  physical memory done.
- pmem_read / pmem_write  out  1  line fill / writeback request; level, held until pmem_resp.
- hit_datapath  in  4  one-hot way hit from the datapath.
- lru_output  in  3  PLRU bits for the current index.
- valid_out / dirty_out  in  4  per-way state for the current index.
- mem_read_delayed / mem_write_delayed  out  1  qualified request, valid in compare states.
- load_lru  out  1; set_lru  out  3  PLRU write.
- load_dirty  out  4; set_dirty  out  1  dirty write and value.
- load_valid / load_tag  out  4  per-way valid set and tag load.
- wren  out  4  per-way data write.
- write_enable_0..3  out  32 each  per-way byte enables.
- mem_enable_sel  out  1  1 = data from pmem_rdata.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; victim register 0. Any pmem_read or pmem_write drops immediately with no completion. Leaving reset returns to IDLE.
- States: IDLE, LOOKUP, WRITEBACK, ALLOCATE, REFILL.
- IDLE: on mem_read|mem_write, go to LOOKUP. The arrays read the index this cycle; data is valid next cycle.
- LOOKUP:
  - *_delayed mirror the registered request type.
  - mem_read and mem_write both high is treated as a write.
  - Hit on way w: mem_resp=1, load_lru=1, go to IDLE.
  - Hit on a write additionally drives wren[w]=1, write_enable_w=mem_byte_enable256, load_dirty[w]=1, set_dirty=1.
  - Multiple hit bits set: lowest way wins (error condition, checked by assertion).
  - Miss: latch victim v. If lru[0]=0, v = lru[1] ? 1 : 0; else v = lru[2] ? 3 : 2.
  - Miss next state: WRITEBACK if valid[v] & dirty[v], else ALLOCATE.
- PLRU update (set_lru = {b2,b1,b0}):
  - way0 -> {lru[2],1,1}
  - way1 -> {lru[2],0,1}
  - way2 -> {1,lru[1],0}
  - way3 -> {0,lru[1],0}
- WRITEBACK: pmem_write=1 until pmem_resp, then go to ALLOCATE. Victim is not modified.
- ALLOCATE: pmem_read=1, mem_enable_sel=1. On pmem_resp, in the same cycle:
  - wren[v]=1, write_enable_v=all ones.
  - load_tag[v]=1, load_valid[v]=1.
  - load_dirty[v]=1, set_dirty=0.
  - Go to REFILL.
- REFILL: single bubble for the synchronous re-read, then go to LOOKUP. That LOOKUP is guaranteed to hit and completes as a normal hit, including PLRU update and write merge.
- Latency: hit = 2 cycles from request to mem_resp. Clean miss = 4 + pmem latency. Dirty miss adds a writeback.
- pmem_read and pmem_write are never asserted together. The pmem_resp strobe is ignored in IDLE, LOOKUP and REFILL.
- Unused write_enable_* and strobes are 0 every cycle.

Optional Feature:
- DCACHE_PERF_CNT_EN: when defined, adds outputs hit_count, miss_count and wb_count (32 bits each).
  - hit_count increments on a LOOKUP hit that is not immediately after REFILL.
  - miss_count increments on a LOOKUP miss.
  - wb_count increments on a WRITEBACK pmem_resp.
  - Counters reset to 0 asynchronously and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dcache_pkg: state enum, way index typedef (2 bits), PLRU typedef (3 bits), line/mask width constants.
- Sub-module dcache_plru (combinational): victim selection and set_lru computation from lru_output and the way index.

Test Plan:
- Cold read, index 3, all invalid, lru=000 -> victim way0; pmem_read until pmem_resp; load_tag[0]/load_valid[0]/wren[0]; REFILL; LOOKUP hit; mem_resp; set_lru=011.
- Write hit, way2, byte_enable=0x0000000F -> wren[2], write_enable_2=0x0000000F, load_dirty[2] with set_dirty=1, set_lru={1,lru[1],0}, mem_resp 2 cycles after request.
- Miss with lru=101, way3 valid+dirty -> victim way3; pmem_write first, then pmem_read; never both high.
- Miss with lru=001, victim way2 clean -> WRITEBACK skipped; pmem_write never asserted.
- rst low during ALLOCATE with pmem_read=1 -> pmem_read=0 same cycle, no mem_resp, IDLE after release.
- With DCACHE_PERF_CNT_EN: 3 hits, 1 dirty miss -> hit_count=3, miss_count=1, wb_count=1.
